ctrl_seq: RTL and testbench

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq.sv | 186 ++++++++++++++++++
 tb/tb_ctrl_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// ctrl_seq: instruction sequencer for a simple load/store datapath.
//
// A 3-bit state register walks START0 -> START1 -> FETCH -> DECODE ->
// EXECUTE -> MEM -> WRITEBACK -> FETCH, with a HALT state entered on the
// HLT opcode and left on a run pulse. All datapath controls are decoded
// combinationally from the present state, the opcode, the mode/mask
// field, the status flags and mem_rdy.
//
// Ports:
//   clk       single clock, all state on the rising edge
//   rst_f     asynchronous active-high reset, forces START0
//   opcode    instruction opcode from IR (OPW bits)
//   mm        mode field / branch condition mask (MMW bits)
//   stat      ALU status flags (MMW bits)
//   mem_rdy   memory access completes this cycle
//   run       resume pulse, sampled only in HALT
//   ir_load   load instruction register
//   pc_write  PC update enable
//   pc_sel    0 = PC+1, 1 = branch address
//   pc_rst    force PC to 0
//   br_sel    1 = absolute branch target, 0 = PC-relative
//   rb_sel    1 = second read port addresses the destination field
//   rf_we     register file write enable
//   wb_sel    0 = ALU result, 1 = memory data
//   mem_we    data memory write enable
//   alu_op    00 reg-reg, 01 immediate, 10 pass/address add
//   halted    controller is in HALT
//   state     present state encoding (debug)
module ctrl_seq #(
    parameter int OPW     = 4,
    parameter int MMW     = 4,
    parameter int WAIT_EN = 1
) (
    input  logic           clk,
    input  logic           rst_f,
    input  logic [OPW-1:0] opcode,
    input  logic [MMW-1:0] mm,
    input  logic [MMW-1:0] stat,
    input  logic           mem_rdy,
    input  logic           run,
    output logic           ir_load,
    output logic           pc_write,
    output logic           pc_sel,
    output logic           pc_rst,
    output logic           br_sel,
    output logic           rb_sel,
    output logic           rf_we,
    output logic           wb_sel,
    output logic           mem_we,
    output logic [1:0]     alu_op,
    output logic           halted,
    output logic [2:0]     state
);

    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [OPW-1:0] OP_LOD = OPW'(1);
    localparam logic [OPW-1:0] OP_STR = OPW'(2);
    localparam logic [OPW-1:0] OP_SWP = OPW'(3);
    localparam logic [OPW-1:0] OP_BRA = OPW'(4);
    localparam logic [OPW-1:0] OP_BRR = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE = OPW'(6);
    localparam logic [OPW-1:0] OP_BNR = OPW'(7);
    localparam logic [OPW-1:0] OP_ALU = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);
    localparam logic [MMW-1:0] MM_IMM = MMW'(8);

    state_t cur_st;
    state_t nxt_st;

    logic rdy;
    logic is_lod, is_str, is_swp, is_alu, is_hlt;
    logic is_mem_op, br_on_set, br_on_clr, br_taken, br_abs;
    logic [1:0] ex_alu_op;

    // With stalls disabled the memory is treated as always ready.
    assign rdy = (WAIT_EN != 0) ? mem_rdy : 1'b1;

    assign is_lod    = (opcode == OP_LOD);
    assign is_str    = (opcode == OP_STR);
    assign is_swp    = (opcode == OP_SWP);
    assign is_alu    = (opcode == OP_ALU);
    assign is_hlt    = (opcode == OP_HLT);
    assign is_mem_op = is_lod | is_str | is_swp;

    // BRA/BRR branch when any masked flag is set, BNE/BNR when none are.
    assign br_on_set = (opcode == OP_BRA) | (opcode == OP_BRR);
    assign br_on_clr = (opcode == OP_BNE) | (opcode == OP_BNR);
    assign br_taken  = (br_on_set & ((stat & mm) != '0)) |
                       (br_on_clr & ((stat & mm) == '0));
    assign br_abs    = (opcode == OP_BRA) | (opcode == OP_BNE);

    assign ex_alu_op = !is_alu        ? 2'b10 :
                       (mm == MM_IMM) ? 2'b01 : 2'b00;

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            cur_st <= S_START0;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st   = cur_st;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        pc_rst   = 1'b0;
        br_sel   = 1'b0;
        rb_sel   = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        mem_we   = 1'b0;
        alu_op   = 2'b10;
        halted   = 1'b0;

        case (cur_st)
            S_START0: begin
                pc_rst = 1'b1;
                nxt_st = S_START1;
            end
            S_START1: begin
                pc_rst = 1'b1;
                nxt_st = S_FETCH;
            end
            S_FETCH: begin
                // PC advances only on the cycle the fetch completes.
                ir_load  = 1'b1;
                pc_write = rdy;
                if (rdy) begin
                    nxt_st = S_DECODE;
                end
            end
            S_DECODE: begin
                nxt_st = is_hlt ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_op = ex_alu_op;
                rb_sel = is_str | is_swp;
                if (br_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = br_abs;
                end
                nxt_st = S_MEM;
            end
            S_MEM: begin
                alu_op = ex_alu_op;
                rb_sel = is_str | is_swp;
                mem_we = is_str | is_swp;
                if (rdy || !is_mem_op) begin
                    nxt_st = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                alu_op = ex_alu_op;
                rb_sel = is_str | is_swp;
                rf_we  = is_alu | is_lod | is_swp;
                wb_sel = is_lod | is_swp;
                nxt_st = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (run) begin
                    nxt_st = S_FETCH;
                end
            end
            default: begin
                nxt_st = S_START0;
            end
        endcase
    end

    assign state = cur_st;

endmodule

// File: tb/tb_ctrl_seq.sv
// Testbench for ctrl_seq. Stimulus tasks drive one cycle at a time and push
// the hand-derived expected state/control word into a scoreboard queue; a
// monitor on the falling edge pops each entry and compares it with the DUT.
module tb_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       mem_rdy;
    logic       run;
    logic       ir_load, pc_write, pc_sel, pc_rst, br_sel, rb_sel;
    logic       rf_we, wb_sel, mem_we, halted;
    logic [1:0] alu_op;
    logic [2:0] state;

    // Flag word order: ir_load pc_write pc_sel pc_rst br_sel rb_sel rf_we wb_sel mem_we halted
    localparam logic [9:0] F_IR = 10'b1000000000;
    localparam logic [9:0] F_PW = 10'b0100000000;
    localparam logic [9:0] F_PS = 10'b0010000000;
    localparam logic [9:0] F_PR = 10'b0001000000;
    localparam logic [9:0] F_BR = 10'b0000100000;
    localparam logic [9:0] F_RB = 10'b0000010000;
    localparam logic [9:0] F_WE = 10'b0000001000;
    localparam logic [9:0] F_WB = 10'b0000000100;
    localparam logic [9:0] F_MW = 10'b0000000010;
    localparam logic [9:0] F_HT = 10'b0000000001;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [9:0] fl;
        logic [1:0] al;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    ctrl_seq #(.OPW(4), .MMW(4), .WAIT_EN(1)) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
        .mem_rdy(mem_rdy), .run(run), .ir_load(ir_load), .pc_write(pc_write),
        .pc_sel(pc_sel), .pc_rst(pc_rst), .br_sel(br_sel), .rb_sel(rb_sel),
        .rf_we(rf_we), .wb_sel(wb_sel), .mem_we(mem_we), .alu_op(alu_op),
        .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] flags_now();
        return {ir_load, pc_write, pc_sel, pc_rst, br_sel, rb_sel,
                rf_we, wb_sel, mem_we, halted};
    endfunction

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: outputs are sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.tag, ".st"}, 16'(state), 16'(e.st));
            chk({e.tag, ".fl"}, 16'(flags_now()), 16'(e.fl));
            chk({e.tag, ".al"}, 16'(alu_op), 16'(e.al));
        end
    end

    // Drive one cycle's inputs and queue the outputs expected during it.
    task automatic cyc(input string tag, input logic [3:0] op, input logic [3:0] m,
                       input logic [3:0] s, input logic rdy,
                       input logic [2:0] est, input logic [9:0] efl, input logic [1:0] eal);
        exp_t e;
        opcode  = op;
        mm      = m;
        stat    = s;
        mem_rdy = rdy;
        e.tag = tag; e.st = est; e.fl = efl; e.al = eal;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One complete instruction from FETCH (ready at once) to WRITEBACK.
    task automatic instr(input string tag, input logic [3:0] op, input logic [3:0] m,
                         input logic [3:0] s, input int mstall,
                         input logic [9:0] f_ex, input logic [9:0] f_mem,
                         input logic [9:0] f_wb, input logic [1:0] ax);
        cyc({tag, ".fe"}, op, m, s, 1'b1, 3'd2, F_IR | F_PW, 2'b10);
        cyc({tag, ".de"}, op, m, s, 1'b1, 3'd3, 10'd0, 2'b10);
        cyc({tag, ".ex"}, op, m, s, 1'b1, 3'd4, f_ex, ax);
        for (int i = 0; i < mstall; i++)
            cyc({tag, ".ms"}, op, m, s, 1'b0, 3'd5, f_mem, ax);
        cyc({tag, ".me"}, op, m, s, 1'b1, 3'd5, f_mem, ax);
        cyc({tag, ".wb"}, op, m, s, 1'b1, 3'd6, f_wb, ax);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_f = 1'b1; opcode = 4'd0; mm = 4'd0; stat = 4'd0; mem_rdy = 1'b1; run = 1'b0;
        #3;
        chk("rst.st", 16'(state), 16'd0);
        chk("rst.fl", 16'(flags_now()), 16'(F_PR));
        chk("rst.al", 16'(alu_op), 16'(2'b10));
        @(posedge clk);
        #1;
        rst_f = 1'b0;

        // Startup then ALU reg-reg: writes only in WRITEBACK with alu_op 00.
        cyc("s0", 4'd8, 4'd0, 4'd0, 1'b1, 3'd0, F_PR, 2'b10);
        cyc("s1", 4'd8, 4'd0, 4'd0, 1'b1, 3'd1, F_PR, 2'b10);
        instr("alu", 4'd8, 4'd0, 4'd0, 0, 10'd0, 10'd0, F_WE, 2'b00);

        // Fetch stall, then LOD stalled 3 cycles in MEM.
        cyc("fst", 4'd1, 4'd0, 4'd0, 1'b0, 3'd2, F_IR, 2'b10);
        instr("lod", 4'd1, 4'd0, 4'd0, 3, 10'd0, 10'd0, F_WE | F_WB, 2'b10);

        // Relative branch taken / not taken.
        instr("brr1", 4'd5, 4'b0010, 4'b0010, 0, F_PW | F_PS, 10'd0, 10'd0, 2'b10);
        instr("brr0", 4'd5, 4'b0010, 4'b0000, 0, 10'd0, 10'd0, 10'd0, 2'b10);

        // Absolute branch-if-clear taken / not taken, BRA taken.
        instr("bne1", 4'd6, 4'b0001, 4'b0000, 0, F_PW | F_PS | F_BR, 10'd0, 10'd0, 2'b10);
        instr("bne0", 4'd6, 4'b0001, 4'b0001, 0, 10'd0, 10'd0, 10'd0, 2'b10);
        instr("bra1", 4'd4, 4'b1100, 4'b0100, 0, F_PW | F_PS | F_BR, 10'd0, 10'd0, 2'b10);
        instr("bnr1", 4'd7, 4'b1000, 4'b0111, 0, F_PW | F_PS, 10'd0, 10'd0, 2'b10);

        // Store with a one-cycle memory stall; ALU immediate; swap.
        instr("str", 4'd2, 4'd0, 4'd0, 1, F_RB, F_RB | F_MW, F_RB, 2'b10);
        instr("imm", 4'd8, 4'd8, 4'd0, 0, 10'd0, 10'd0, F_WE, 2'b01);
        instr("swp", 4'd3, 4'd0, 4'd0, 0, F_RB, F_RB | F_MW, F_RB | F_WE | F_WB, 2'b10);

        // Unassigned opcode decodes as NOOP; run outside HALT is ignored.
        run = 1'b1;
        instr("und", 4'd10, 4'd0, 4'd0, 0, 10'd0, 10'd0, 10'd0, 2'b10);
        run = 1'b0;

        // HLT: held in HALT while run is low, leaves on a run pulse.
        cyc("hlt.fe", 4'd15, 4'd0, 4'd0, 1'b1, 3'd2, F_IR | F_PW, 2'b10);
        cyc("hlt.de", 4'd15, 4'd0, 4'd0, 1'b1, 3'd3, 10'd0, 2'b10);
        for (int i = 0; i < 5; i++)
            cyc("hlt.hd", 4'd15, 4'd0, 4'd0, 1'b1, 3'd7, F_HT, 2'b10);
        run = 1'b1;
        cyc("hlt.rn", 4'd15, 4'd0, 4'd0, 1'b1, 3'd7, F_HT, 2'b10);
        run = 1'b0;

        // Store that stalls in MEM, then an asynchronous reset mid-stall.
        cyc("rs.fe", 4'd2, 4'd0, 4'd0, 1'b1, 3'd2, F_IR | F_PW, 2'b10);
        cyc("rs.de", 4'd2, 4'd0, 4'd0, 1'b1, 3'd3, 10'd0, 2'b10);
        cyc("rs.ex", 4'd2, 4'd0, 4'd0, 1'b1, 3'd4, F_RB, 2'b10);
        cyc("rs.m1", 4'd2, 4'd0, 4'd0, 1'b0, 3'd5, F_RB | F_MW, 2'b10);
        cyc("rs.m2", 4'd2, 4'd0, 4'd0, 1'b0, 3'd5, F_RB | F_MW, 2'b10);
        #2;
        chk("rs.pre_mw", 16'(mem_we), 16'd1);
        run   = 1'b1;
        rst_f = 1'b1;
        #1;
        chk("rs.async_st", 16'(state), 16'd0);
        chk("rs.async_fl", 16'(flags_now()), 16'(F_PR));
        chk("rs.async_al", 16'(alu_op), 16'(2'b10));
        @(posedge clk);
        #1;
        chk("rs.hold_st", 16'(state), 16'd0);
        rst_f = 1'b0;
        run   = 1'b0;
        cyc("rr.s0", 4'd0, 4'd0, 4'd0, 1'b1, 3'd0, F_PR, 2'b10);
        cyc("rr.s1", 4'd0, 4'd0, 4'd0, 1'b1, 3'd1, F_PR, 2'b10);
        cyc("rr.fe", 4'd0, 4'd0, 4'd0, 1'b1, 3'd2, F_IR | F_PW, 2'b10);

        @(negedge clk);
        #1;
        chk("sbq_drain", 16'(sbq.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
